input_buffer_reader: RTL and testbench
======================================

# input_buffer_reader

Raster-scan reader for the input pixel buffer. On a start pulse it walks every (x, y) location of the frame, drives the buffer read coordinates, and captures the returned 24-bit pixels. It presents the pixels as a valid/ready stream, with start-of-frame, end-of-line and end-of-frame markers, to the first convolution stage. It is the read-side counterpart of the buffer's write port and absorbs the buffer's one-cycle read latency with a 2-entry skid FIFO.

## Interface
- IMG_W, 416, frame width in pixels (1..2047)
- IMG_H, 416, frame height in pixels (1..2047)
- PIXEL_W, 24, pixel width (RGB888)
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse; begins a frame scan when idle, ignored otherwise
- buf_x  output  11  read x coordinate to buffer
- buf_y  output  11  read y coordinate to buffer
- buf_re  output  1  read strobe; buffer returns data exactly 1 cycle later
- buf_rdata  input  PIXEL_W  buffer read data, valid the cycle after buf_re
- pix_data  output  PIXEL_W  stream pixel
- pix_valid  output  1  stream valid
- pix_ready  input  1  downstream ready
- pix_sof  output  1  marks pixel (0,0)
- pix_eol  output  1  marks x = IMG_W-1
- pix_eof  output  1  marks (IMG_W-1, IMG_H-1)
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse after the last pixel handshake

## Operation
- State machine with states IDLE, SCAN, DRAIN, DONE.
  - IDLE -> SCAN on start. Clear the x/y issue counters.
  - SCAN: issue one read per cycle while credit allows. After issuing (IMG_W-1, IMG_H-1), go to DRAIN.
  - DRAIN: issue nothing. Go to DONE when the FIFO is empty and no read is in flight.
  - DONE: assert done for one cycle, then return to IDLE.
- Credit rule: buf_re = 1 only if (FIFO occupancy + reads in flight) < 2. At most one read is in flight.
- Issue counters:
  - x increments per read.
  - At x = IMG_W-1, x wraps to 0 and y increments.
  - y never exceeds IMG_H-1.
- Each read carries the sof/eol/eof flags computed from the issued coordinates, delayed 1 cycle alongside the data.
- Write buf_rdata and the flags into the FIFO in the cycle after buf_re.
- pix_* reflects the FIFO head. pix_valid = FIFO not empty.
- Pop the FIFO on pix_valid & pix_ready. A push and a pop in the same cycle are both honoured, and occupancy is unchanged.
- pix_data and the flags hold stable while pix_valid=1 and pix_ready=0.
- start while busy is ignored.
- Reset mid-frame aborts the scan: the FIFO is emptied and the in-flight read is discarded.

## Timing
- Reset values:
  - buf_x = 0, buf_y = 0, buf_re = 0
  - pix_valid = 0, pix_data = 0, pix_sof = pix_eol = pix_eof = 0
  - busy = 0, done = 0
  - state IDLE
- start at cycle T:
  - first buf_re at T+1 with (0,0)
  - first pix_valid at T+2 with pix_sof=1
- Steady-state throughput is 1 pixel/cycle with pix_ready held high.
  - Frame of N = IMG_W·IMG_H pixels: last handshake at T+N+1, done at T+N+2.
- Backpressure:
  - pix_ready low stalls issue within 1 cycle; the FIFO holds at most 2 entries.
  - No pixel is lost or duplicated.
  - When ready returns, the output resumes with the buffered pixels in order.
- busy falls in the same cycle done rises.

## Test plan
- Reset and idle:
  - Stimulus: hold rst_n=0 for 2 cycles, then release with no start.
  - Required: all outputs 0, buf_re never asserts.
- Full frame, no backpressure:
  - Stimulus: IMG_W=4, IMG_H=3, buffer model returns {y,x}-coded data, pix_ready=1.
  - Required: 12 pixels in raster order, sof on pixel 0, eol on pixels 3/7/11, eof on pixel 11, done at T+14.
- Random backpressure:
  - Stimulus: pix_ready toggled pseudo-randomly at 50%.
  - Required: identical 12-pixel sequence; pix_data stable during stalls; occupancy never exceeds 2.
- Long stall:
  - Stimulus: pix_ready=0 for 10 cycles starting at pixel 5.
  - Required: buf_re stops after FIFO+in-flight reach 2; pixels 5 and 6 are delivered next, with no gap in the sequence.
- Start while busy and reset mid-frame:
  - Stimulus: second start at pixel 3, then rst_n=0 at pixel 6.
  - Required: the second start is ignored; after reset pix_valid=0 and busy=0; a new start restarts at (0,0) with sof.
- 1x1 frame:
  - Stimulus: IMG_W=1, IMG_H=1.
  - Required: a single pixel with sof=eol=eof=1, done two cycles after its issue.

Source files
------------

// File: rtl/input_buffer_reader.sv
// -----------------------------------------------------------------------------
// input_buffer_reader
//
// Raster-scan reader for the input pixel buffer. A start pulse launches one
// full-frame scan: every (x, y) location is read in raster order, the returned
// pixels are captured, and they are presented as a valid/ready stream with
// start-of-frame / end-of-line / end-of-frame markers.
//
// The buffer has a fixed one-cycle read latency. Issue is credit-limited so
// that buffered pixels plus the read in flight never exceed two, which lets a
// 2-entry skid FIFO absorb any downstream stall without losing data. The FIFO
// is fall-through: a returning read goes straight to the output when the FIFO
// is empty, so the first pixel is valid the cycle its data arrives.
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset (aborts any scan in progress)
//   start      in   one-cycle pulse, starts a frame when idle
//   buf_x      out  [10:0] buffer read x coordinate
//   buf_y      out  [10:0] buffer read y coordinate
//   buf_re     out  buffer read strobe (data returns one cycle later)
//   buf_rdata  in   [PIXEL_W-1:0] buffer read data
//   pix_data   out  [PIXEL_W-1:0] stream pixel (FIFO head)
//   pix_valid  out  stream valid
//   pix_ready  in   downstream ready
//   pix_sof    out  head pixel is (0,0)
//   pix_eol    out  head pixel is the last of its line
//   pix_eof    out  head pixel is the last of the frame
//   busy       out  scan in progress
//   done       out  one-cycle pulse after the last pixel handshake
// -----------------------------------------------------------------------------
module input_buffer_reader #(
    parameter int IMG_W   = 416,
    parameter int IMG_H   = 416,
    parameter int PIXEL_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [10:0]        buf_x,
    output logic [10:0]        buf_y,
    output logic               buf_re,
    input  logic [PIXEL_W-1:0] buf_rdata,
    output logic [PIXEL_W-1:0] pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_sof,
    output logic               pix_eol,
    output logic               pix_eof,
    output logic               busy,
    output logic               done
);

    localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
    localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [PIXEL_W-1:0] data;
        logic               sof;
        logic               eol;
        logic               eof;
    } entry_t;

    state_t      state, state_next;

    logic [10:0] x_cnt, y_cnt;
    logic        issue;
    logic        issue_sof, issue_eol, issue_eof;

    // Read in flight: flags travel alongside the one-cycle read latency.
    logic        rd_pending;
    logic        sof_d, eol_d, eof_d;

    entry_t      mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count, count_next;
    entry_t      in_entry, head;
    logic        pix_fire, push, pop_mem;

    // -------------------------------------------------------------------------
    // Issue side
    // -------------------------------------------------------------------------
    assign issue_sof = (x_cnt == '0) && (y_cnt == '0);
    assign issue_eol = (x_cnt == X_LAST);
    assign issue_eof = issue_eol && (y_cnt == Y_LAST);

    // Credit: buffered entries plus the read in flight must stay below two.
    assign issue  = (state == ST_SCAN) &&
                    (({1'b0, count} + {2'b0, rd_pending}) < 3'd2);
    assign buf_re = issue;
    assign buf_x  = x_cnt;
    assign buf_y  = y_cnt;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            rd_pending <= 1'b0;
            sof_d      <= 1'b0;
            eol_d      <= 1'b0;
            eof_d      <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (issue) begin
                if (issue_eol) begin
                    x_cnt <= '0;
                    // y saturates on the last line; the scan ends there anyway.
                    if (y_cnt != Y_LAST) y_cnt <= y_cnt + 11'd1;
                end else begin
                    x_cnt <= x_cnt + 11'd1;
                end
            end
            rd_pending <= issue;
            sof_d      <= issue_sof;
            eol_d      <= issue_eol;
            eof_d      <= issue_eof;
        end
    end

    // -------------------------------------------------------------------------
    // Fall-through skid FIFO
    // -------------------------------------------------------------------------
    assign in_entry  = '{data: buf_rdata, sof: sof_d, eol: eol_d, eof: eof_d};
    assign head      = (count != 2'd0) ? mem[rd_ptr] : in_entry;
    assign pix_valid = (count != 2'd0) || rd_pending;
    assign pix_fire  = pix_valid && pix_ready;

    // A returning pixel consumed directly from the bypass is never stored.
    assign push    = rd_pending && !((count == 2'd0) && pix_fire);
    assign pop_mem = pix_fire && (count != 2'd0);
    assign count_next = count + {1'b0, push} - {1'b0, pop_mem};

    // Outputs are forced to zero when nothing is valid so the stream never
    // exposes stale buffer data.
    assign pix_data = pix_valid ? head.data : '0;
    assign pix_sof  = pix_valid && head.sof;
    assign pix_eol  = pix_valid && head.eol;
    assign pix_eof  = pix_valid && head.eof;

    // NOTE: the storage array has no reset; the occupancy count is reset, so
    // stale entries are never presented.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push)    wr_ptr <= ~wr_ptr;
            if (pop_mem) rd_ptr <= ~rd_ptr;
            count <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned (which would infer a latch).
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (issue && issue_eof) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Nothing is issued here, so after this edge nothing is in
                // flight; finish as soon as the last entry leaves this cycle.
                if (count_next == 2'd0 && !push) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_input_buffer_reader.sv
// -----------------------------------------------------------------------------
// Testbench for input_buffer_reader: a 4x3 instance exercised with directed
// frames (free-running, random backpressure, long stall, start-while-busy plus
// mid-frame reset) and a 1x1 instance. The buffer models return
// {1, y, 1, x}-coded pixels one cycle after each read strobe.
// -----------------------------------------------------------------------------
module tb_input_buffer_reader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    // 4x3 instance
    logic          start = 1'b0;
    logic          pix_ready = 1'b0;
    logic [10:0]   buf_x, buf_y;
    logic          buf_re;
    logic [PW-1:0] buf_rdata;
    logic [PW-1:0] pix_data;
    logic          pix_valid, pix_sof, pix_eol, pix_eof, busy, done;

    // 1x1 instance
    logic          start1 = 1'b0;
    logic          ready1 = 1'b1;
    logic [10:0]   buf_x1, buf_y1;
    logic          buf_re1;
    logic [PW-1:0] buf_rdata1;
    logic [PW-1:0] pix_data1;
    logic          pix_valid1, pix_sof1, pix_eol1, pix_eof1, busy1, done1;

    input_buffer_reader #(.IMG_W(W), .IMG_H(H), .PIXEL_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .buf_x(buf_x), .buf_y(buf_y), .buf_re(buf_re), .buf_rdata(buf_rdata),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .done(done)
    );

    input_buffer_reader #(.IMG_W(1), .IMG_H(1), .PIXEL_W(PW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .buf_x(buf_x1), .buf_y(buf_y1), .buf_re(buf_re1), .buf_rdata(buf_rdata1),
        .pix_data(pix_data1), .pix_valid(pix_valid1), .pix_ready(ready1),
        .pix_sof(pix_sof1), .pix_eol(pix_eol1), .pix_eof(pix_eof1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] code(input logic [10:0] x, input logic [10:0] y);
        return {1'b1, y, 1'b1, x};
    endfunction

    // Expected {data, sof, eol, eof} of raster pixel i in the 4x3 frame.
    function automatic logic [PW+2:0] exp_pix(input int i);
        logic [10:0] x, y;
        x = 11'(i % W);
        y = 11'(i / W);
        return {code(x, y), i == 0, (i % W) == W - 1, i == N - 1};
    endfunction

    // Buffer models: one-cycle registered read, garbage when not strobed.
    always @(posedge clk) begin
        buf_rdata  <= buf_re  ? code(buf_x, buf_y)   : 24'h5A5A5A;
        buf_rdata1 <= buf_re1 ? code(buf_x1, buf_y1) : 24'h5A5A5A;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    int cyc = 0;

    task automatic tick;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Per-frame observation state
    int            hs, issued, re_in_stall, done_cyc, t0;
    int            hs_cyc [N];
    logic          prev_stall;
    logic [PW+2:0] prev_head;

    task automatic observe(input int mode);
        logic [PW+2:0] head;
        head = {pix_data, pix_sof, pix_eol, pix_eof};
        if (prev_stall) begin
            check("hold_valid", pix_valid, 1'b1);
            check("hold_head", head, prev_head);
        end
        check("occupancy_le2", (issued - hs) <= 2, 1'b1);
        if (pix_valid && pix_ready) begin
            if (hs < N) begin
                check($sformatf("pixel%0d", hs), head, exp_pix(hs));
                hs_cyc[hs] = cyc;
            end
            hs++;
        end
        if (buf_re) begin
            issued++;
            if (mode == 2 && !pix_ready) re_in_stall++;
        end
        if (done && done_cyc < 0) begin
            done_cyc = cyc;
            check("busy_low_at_done", busy, 1'b0);
        end
        prev_stall = pix_valid && !pix_ready;
        prev_head  = head;
    endtask

    // mode 0: ready high, 1: random ready, 2: 10-cycle stall at pixel 5,
    // 3: second start during the scan, then reset mid-frame.
    task automatic run_frame(input int mode);
        int   stall_left;
        bit   stall_done, start2, aborted;
        hs = 0; issued = 0; re_in_stall = 0; done_cyc = -1;
        prev_stall = 1'b0; prev_head = '0;
        stall_left = 0; stall_done = 0; start2 = 0; aborted = 0;
        pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 300 && done_cyc < 0 && !aborted; k++) begin
            @(negedge clk);
            observe(mode);
            if (cyc == t0 + 1) begin
                check("busy_after_start", busy, 1'b1);
                check("first_re", buf_re, 1'b1);
                check("first_xy", {buf_x, buf_y}, 22'd0);
            end
            if (cyc == t0 + 2) check("first_valid_sof", {pix_valid, pix_sof}, 2'b11);
            tick;
            start = 1'b0;
            if (mode == 3 && hs >= 3 && !start2) begin
                start  = 1'b1;
                start2 = 1;
            end
            if (mode == 3 && hs >= 6) begin
                rst_n   = 1'b0;
                aborted = 1;
            end
            if (mode == 1) begin
                pix_ready = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                if (hs == 5 && !stall_done) begin
                    stall_left = 10;
                    stall_done = 1;
                end
                if (stall_left > 0) begin
                    pix_ready = 1'b0;
                    stall_left--;
                end else begin
                    pix_ready = 1'b1;
                end
            end
        end
        if (mode != 3) begin
            check("frame_done_seen", done_cyc >= 0, 1'b1);
            check("pixel_count", hs, N);
        end
        if (mode == 0) check("done_cycle", done_cyc - t0, N + 2);
        if (mode == 2) begin
            check("done_cycle_stall", done_cyc - t0, N + 2 + 10);
            check("re_during_stall", re_in_stall, 1);
            check("resume_pix5", hs_cyc[5] - t0, 17);
            check("resume_pix6", hs_cyc[6] - t0, 18);
        end
        if (mode == 3) begin
            @(negedge clk);
            tick;
            @(negedge clk);
            check("rst_valid", pix_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_re", buf_re, 1'b0);
            tick;
            rst_n = 1'b1;
        end
        pix_ready = 1'b1;
        repeat (2) tick;
    endtask

    initial begin
        int t1, re_cyc1, pix_cyc1, done_cyc1;

        // Reset and idle
        rst_n = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs",
              {pix_valid, pix_sof, pix_eol, pix_eof, busy, done, buf_re}, 7'd0);
        check("idle_data", pix_data, 24'd0);
        check("idle_xy", {buf_x, buf_y}, 22'd0);
        check("idle1_outputs", {pix_valid1, busy1, done1, buf_re1}, 4'd0);
        for (int i = 0; i < 4; i++) begin
            tick;
            @(negedge clk);
            check("idle_no_re", buf_re, 1'b0);
        end
        tick;

        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(3);
        run_frame(0);

        // 1x1 frame
        start1 = 1'b1;
        t1 = cyc;
        re_cyc1 = -1; pix_cyc1 = -1; done_cyc1 = -1;
        for (int k = 0; k < 20 && done_cyc1 < 0; k++) begin
            @(negedge clk);
            if (buf_re1 && re_cyc1 < 0) re_cyc1 = cyc;
            if (pix_valid1 && ready1 && pix_cyc1 < 0) begin
                pix_cyc1 = cyc;
                check("p1x1_data", pix_data1, code(11'd0, 11'd0));
                check("p1x1_flags", {pix_sof1, pix_eol1, pix_eof1}, 3'b111);
            end
            if (done1 && done_cyc1 < 0) done_cyc1 = cyc;
            tick;
            start1 = 1'b0;
        end
        check("p1x1_issue_cycle", re_cyc1 - t1, 1);
        check("p1x1_pix_cycle", pix_cyc1 - t1, 2);
        check("p1x1_done_cycle", done_cyc1 - re_cyc1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
